hack_cpu_ctrl: RTL and testbench
================================

# hack_cpu_ctrl

Multi-cycle control unit for the HACK CPU. It sits on the opposite side of the HACK ALU's interface from the ALU itself: it drives the ALU's x, y and 6-bit control inputs, and consumes the ALU's out, zr and ng. It owns the A, D and PC registers, fetches and decodes instructions, sequences data-memory reads and writes through ready/ack handshakes, and resolves jumps from zr/ng.

## Interface
Parameters: none.

- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  15  instruction address (= PC)
- imem_req  out  1  instruction fetch request
- imem_valid  in  1  imem_data valid this cycle
- imem_data  in  16  instruction word
- dmem_addr  out  15  data address
- dmem_rd  out  1  read strobe, held until dmem_ack
- dmem_wr  out  1  write strobe, held until dmem_ack
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data, valid with dmem_ack
- dmem_ack  in  1  completes current rd/wr
- alu_x  out  16  always D
- alu_y  out  16  IR[12] ? MDR : A
- alu_control  out  6  IR[11:6] = {zx,nx,zy,ny,f,no}
- alu_out  in  16  ALU result
- alu_zr  in  1  result zero
- alu_ng  in  1  result negative
- pc  out  15  current PC
- a_reg  out  16  A register
- d_reg  out  16  D register
- halted  out  1  only with HACK_HALT_DETECT_EN; otherwise absent

## Operation
- States: FETCH, DECODE, READ, EXEC, WRITE (HALT with macro).
- FETCH: imem_req=1 and imem_addr=PC. On imem_valid, latch IR, then go to DECODE.
- DECODE:
  - IR[15]=0 (A-instr): A<=IR, PC<=PC+1, then FETCH.
  - IR[15]=1: if IR[12]=1, go to READ; else go to EXEC.
  - IR[14:13] are ignored.
- READ: dmem_rd=1, dmem_addr=A[14:0]. On dmem_ack, MDR<=dmem_rdata, then go to EXEC.
- EXEC: the ALU is combinational and is sampled in this same cycle.
  - Destinations: IR[5] writes A, IR[4] writes D, IR[3] writes M.
  - If IR[3]: WA<=A[14:0] (old A), WD<=alu_out, then go to WRITE.
  - Otherwise go to FETCH.
- Jump: take = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr).
  - If taken, PC<=old A[14:0]; otherwise PC<=PC+1.
  - PC update happens in EXEC.
- WRITE: dmem_wr=1, dmem_addr=WA, dmem_wdata=WD. On dmem_ack, go to FETCH.
- Simultaneous-event rules:
  - Destination A combined with a jump: the jump target and WA use the pre-update A.
  - alu_x always uses the pre-update D.
- PC wraps 0x7FFF -> 0x0000.
- dmem_rd and dmem_wr are never both high. imem_req is never high outside FETCH.

## Timing
- Reset values: state=FETCH; PC, A, D, IR, MDR, WA, WD = 0; imem_req, dmem_rd, dmem_wr, halted = 0.
- Consequences of reset: alu_control=000000 and imem_req rises in the first cycle after reset.
- Cycle counts with zero-wait memory (valid/ack in the first requesting cycle):
  - A-instr: 2 cycles.
  - C-instr: 3 cycles.
  - +1 cycle with an M operand.
  - +1 cycle with an M destination.
- Each memory wait cycle adds 1 cycle. Strobes and addresses are held stable while waiting.
- Reset mid-operation (any state): return to FETCH next cycle, all strobes low, no register update from the aborted instruction.
- imem_valid or dmem_ack outside the matching state: ignored.

## Configuration
- HACK_HALT_DETECT_EN defined:
  - In EXEC, an unconditional jump (IR[2:0]=111) with old A[14:0]==PC enters HALT.
  - HALT asserts halted=1, keeps all strobes low, and exits only on reset.
- Without the macro: no HALT state, no halted port, and self-loops execute forever.

## Structure
- Package hack_pkg holds:
  - state enum;
  - instruction field localparams (IS_C=15, A_SEL=12, COMP range, DEST, JUMP);
  - function jump_taken(jbits, zr, ng).
- One sub-module, hack_jump_cond: combinational jump predicate, reusable by the bench scoreboard.

## Test plan
- Reset, imem returns 0x0005 at PC 0 -> after 2 cycles A=0x0005, PC=1, D=0.
- @7 then 0xEC10 (D=A) -> alu_control=110000 in EXEC, D=7, PC=2.
- A=100, D=7, 0xE308 (M=D), ack delayed 3 cycles -> dmem_wr high 4 cycles at addr 100, wdata 0x0007. PC increments once.
- D=7, A=100, 0xF090 (D=D+M), rdata=3 -> READ then EXEC, D=10.
- 0xE301 (D;JGT), A=20: with D=10 -> PC=20; with D=0 -> PC=PC+1; with D=0xFFFF -> PC+1.
- Reset asserted during WRITE wait -> dmem_wr low next cycle, PC=0, A=D=0.
- With HACK_HALT_DETECT_EN: PC=4, A=4, 0xEA87 (0;JMP) -> halted=1, imem_req stays 0.

Source files
------------

// File: rtl/hack_pkg.sv
// hack_pkg: shared definitions for the HACK CPU control unit.
// Holds the controller state encoding, instruction field positions and
// the jump predicate used by both the controller and its jump sub-block.
// Optional macro HACK_HALT_DETECT_EN adds the HALT state encoding.
package hack_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } hack_state_e;

    localparam logic [2:0] ST_FETCH  = S_FETCH;
    localparam logic [2:0] ST_DECODE = S_DECODE;
    localparam logic [2:0] ST_READ   = S_READ;
    localparam logic [2:0] ST_EXEC   = S_EXEC;
    localparam logic [2:0] ST_WRITE  = S_WRITE;
`ifdef HACK_HALT_DETECT_EN
    localparam logic [2:0] ST_HALT   = S_HALT;
`endif

    localparam int IS_C    = 15;
    localparam int A_SEL   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    function automatic logic jump_taken(input logic [2:0] jbits,
                                        input logic       zr,
                                        input logic       ng);
        return (jbits[2] & ng) | (jbits[1] & zr) | (jbits[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_jump_cond.sv
// hack_jump_cond: combinational jump predicate for HACK C-instructions.
// Decides from the three jump bits and the ALU flags whether PC loads A.
module hack_jump_cond
    import hack_pkg::*;
(
    input  logic [2:0] jbits,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    // Evaluate the jump condition against the current ALU flags.
    always_comb begin
        take = jump_taken(jbits, zr, ng);
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle HACK CPU control unit.
// Owns A, D, PC, IR, MDR and the pending write (WA/WD); drives the external
// ALU and sequences instruction fetch and data-memory reads/writes through
// valid/ack handshakes. Optional macro HACK_HALT_DETECT_EN adds a HALT state
// entered on an unconditional jump to the current PC, and the halted port.
module hack_cpu_ctrl
    import hack_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [14:0] dmem_addr,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_control,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [14:0] pc,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg
`ifdef HACK_HALT_DETECT_EN
    ,
    output logic        halted
`endif
);

    logic [2:0]  state;
    logic [15:0] ir;
    logic [15:0] mdr;
    logic [14:0] wa;
    logic [15:0] wd;
    logic [14:0] pc_inc;
    logic        jump_take;
    logic        unused_ir_bits;

    hack_jump_cond u_jump (
        .jbits (ir[JUMP_HI:JUMP_LO]),
        .zr    (alu_zr),
        .ng    (alu_ng),
        .take  (jump_take)
    );

`ifdef HACK_HALT_DETECT_EN
    logic halt_hit;

    // A taken unconditional jump onto itself can never leave, so it halts.
    always_comb begin
        halt_hit = (ir[JUMP_HI:JUMP_LO] == 3'b111) && (a_reg[14:0] == pc);
    end
`endif

    // Sequential PC candidate and the intentionally ignored IR[14:13] bits.
    always_comb begin
        pc_inc         = pc + 15'd1;
        unused_ir_bits = ^ir[14:13];
    end

    // Controller FSM and architectural register updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            pc    <= '0;
            a_reg <= '0;
            d_reg <= '0;
            ir    <= '0;
            mdr   <= '0;
            wa    <= '0;
            wd    <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_valid) begin
                        ir    <= imem_data;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!ir[IS_C]) begin
                        a_reg <= ir;
                        pc    <= pc_inc;
                        state <= ST_FETCH;
                    end else if (ir[A_SEL]) begin
                        state <= ST_READ;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_READ: begin
                    if (dmem_ack) begin
                        mdr   <= dmem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (ir[DEST_A]) a_reg <= alu_out;
                    if (ir[DEST_D]) d_reg <= alu_out;
                    pc <= jump_take ? a_reg[14:0] : pc_inc;
                    if (ir[DEST_M]) begin
                        wa    <= a_reg[14:0];
                        wd    <= alu_out;
                        state <= ST_WRITE;
                    end else begin
                        state <= ST_FETCH;
                    end
`ifdef HACK_HALT_DETECT_EN
                    if (halt_hit) state <= ST_HALT;
`endif
                end
                ST_WRITE: begin
                    if (dmem_ack) state <= ST_FETCH;
                end
`ifdef HACK_HALT_DETECT_EN
                ST_HALT: begin
                    state <= ST_HALT;
                end
`endif
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    // Strobes follow the state but are forced low while reset is asserted.
    always_comb begin
        imem_req    = (state == ST_FETCH) && !reset;
        dmem_rd     = (state == ST_READ)  && !reset;
        dmem_wr     = (state == ST_WRITE) && !reset;
        imem_addr   = pc;
        dmem_addr   = (state == ST_WRITE) ? wa : a_reg[14:0];
        dmem_wdata  = wd;
        alu_x       = d_reg;
        alu_y       = ir[A_SEL] ? mdr : a_reg;
        alu_control = ir[COMP_HI:COMP_LO];
`ifdef HACK_HALT_DETECT_EN
        halted      = (state == ST_HALT) && !reset;
`endif
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: self-checking bench for hack_cpu_ctrl.
// An instruction-level HACK model predicts architectural state, memory
// traffic and per-instruction cycle counts; a monitor compares the DUT
// against those predictions each time it starts a new fetch or strobes
// data memory. Honours HACK_HALT_DETECT_EN for the halted port.
module tb_hack_cpu_ctrl;

    localparam int ZERO_WAIT_INSTR = 200;
    localparam int RANDOM_INSTR    = 1400;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] imem_addr;
    logic        imem_req;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [14:0] dmem_addr;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_control;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [14:0] pc;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
`ifdef HACK_HALT_DETECT_EN
    logic        halted;
`endif

    hack_cpu_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .dmem_addr   (dmem_addr),
        .dmem_rd     (dmem_rd),
        .dmem_wr     (dmem_wr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .pc          (pc),
        .a_reg       (a_reg),
        .d_reg       (d_reg)
`ifdef HACK_HALT_DETECT_EN
        ,
        .halted      (halted)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
        int          len;
    } arch_t;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    arch_t       exp_state[$];
    wr_t         exp_wr[$];
    logic [14:0] exp_rd[$];
    logic [15:0] dir_words[$];

    logic [15:0] ref_mem [0:32767];
    logic [15:0] dut_mem [0:32767];
    logic [14:0] m_pc;
    logic [15:0] m_a;
    logic [15:0] m_d;
    bit          m_halted;

    int checks  = 0;
    int errors  = 0;
    int issued  = 0;
    int budget  = 0;
    int max_wait = 0;
    int iwait   = 0;
    int rw_cur  = 0;
    int ww_cur  = 0;
    bit checking = 0;
    bit hold_ack = 0;

    // Textbook HACK ALU, used as the environment and inside the model.
    function automatic logic [15:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    // Combinational ALU attached to the controller's ALU interface.
    always_comb begin
        alu_out = alu_fn(alu_x, alu_y, alu_control);
        alu_zr  = (alu_out == 16'h0000);
        alu_ng  = alu_out[15];
    end

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 99) < 35) begin
            w[15] = 1'b0;
        end else begin
            w[15] = 1'b1;
            if ($urandom_range(0, 99) < 65) w[2:0] = 3'b000;
        end
        return w;
    endfunction

    function automatic int pick_wait();
        return (max_wait == 0) ? 0 : int'($urandom_range(0, max_wait));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] w);
        dir_words.push_back(w);
        budget++;
    endtask

    // Instruction-level reference: execute one word, record what must follow.
    task automatic model_step(input logic [15:0] w, input int fw, input int rw, input int ww);
        arch_t       s;
        logic [15:0] y, r, old_a;
        int          sr, len;
        bit          halting;
        halting = 0;
        if (!w[15]) begin
            m_a  = w;
            m_pc = m_pc + 15'd1;
            len  = 2 + fw;
        end else begin
            old_a = m_a;
            len   = 3 + fw;
            if (w[12]) begin
                y = ref_mem[old_a[14:0]];
                exp_rd.push_back(old_a[14:0]);
                len += 1 + rw;
            end else begin
                y = old_a;
            end
            r  = alu_fn(m_d, y, w[11:6]);
            sr = int'($signed(r));
`ifdef HACK_HALT_DETECT_EN
            halting = (w[2:0] == 3'b111) && (old_a[14:0] == m_pc);
`endif
            if (w[3] && !halting) begin
                exp_wr.push_back('{old_a[14:0], r});
                ref_mem[old_a[14:0]] = r;
                len += 1 + ww;
            end
            if (w[5]) m_a = r;
            if (w[4]) m_d = r;
            if ((w[2] && sr < 0) || (w[1] && sr == 0) || (w[0] && sr > 0))
                m_pc = old_a[14:0];
            else
                m_pc = m_pc + 15'd1;
        end
        if (halting) m_halted = 1;
        s.pc  = m_pc;
        s.a   = m_a;
        s.d   = m_d;
        s.len = len;
        if (!m_halted) exp_state.push_back(s);
    endtask

    // Instruction memory responder: delivers words after a random wait and
    // hands each delivered word to the model.
    initial begin
        int icnt;
        icnt = 0;
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        forever begin
            @(negedge clk);
            if (imem_valid) begin
                imem_valid = 1'b0;
                rw_cur = pick_wait();
                ww_cur = pick_wait();
                model_step(imem_data, iwait, rw_cur, ww_cur);
                issued++;
                if (m_halted) budget = 0;
                iwait = pick_wait();
                icnt  = 0;
                imem_data = 16'($urandom);
            end else if (reset) begin
                icnt = 0;
            end else if (imem_req && budget > 0) begin
                if (icnt >= iwait) begin
                    imem_valid = 1'b1;
                    imem_data  = (dir_words.size() > 0) ? dir_words.pop_front() : rand_word();
                    budget--;
                end else begin
                    icnt++;
                end
            end
        end
    end

    // Data memory responder: acknowledges reads and writes after a wait.
    initial begin
        int dcnt;
        dcnt = 0;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (dmem_ack) begin
                dmem_ack   = 1'b0;
                dmem_rdata = 16'($urandom);
                dcnt       = 0;
            end else if (reset) begin
                dcnt = 0;
            end else if ((dmem_rd || dmem_wr) && !hold_ack) begin
                if (dcnt >= (dmem_rd ? rw_cur : ww_cur)) begin
                    dmem_ack = 1'b1;
                    if (dmem_rd) dmem_rdata = dut_mem[dmem_addr];
                    else         dut_mem[dmem_addr] = dmem_wdata;
                end else begin
                    dcnt++;
                end
            end
        end
    end

    // Monitor: compare DUT state at each new fetch and memory traffic per cycle.
    initial begin
        arch_t       s;
        wr_t         cur_wr;
        logic [14:0] cur_rd;
        logic        prev_req, prev_wr, prev_rd;
        int          cyc;
        prev_req = 1'b0;
        prev_wr  = 1'b0;
        prev_rd  = 1'b0;
        cyc      = 0;
        cur_wr   = '{15'h0, 16'h0};
        cur_rd   = 15'h0;
        forever begin
            @(negedge clk);
            if (checking) begin
                cyc++;
                if (imem_req && !prev_req) begin
                    checkOutput("state_queue_nonempty", 32'(exp_state.size() > 0), 1);
                    if (exp_state.size() > 0) begin
                        s = exp_state.pop_front();
                        checkOutput("pc", 32'(pc), 32'(s.pc));
                        checkOutput("imem_addr", 32'(imem_addr), 32'(s.pc));
                        checkOutput("a_reg", 32'(a_reg), 32'(s.a));
                        checkOutput("d_reg", 32'(d_reg), 32'(s.d));
                        if (s.len >= 0) checkOutput("cycles", 32'(cyc), 32'(s.len));
                    end
                    cyc = 0;
                end
                if (dmem_wr) begin
                    if (!prev_wr) begin
                        checkOutput("wr_queue_nonempty", 32'(exp_wr.size() > 0), 1);
                        if (exp_wr.size() > 0) cur_wr = exp_wr.pop_front();
                    end
                    checkOutput("wr_addr", 32'(dmem_addr), 32'(cur_wr.addr));
                    checkOutput("wr_data", 32'(dmem_wdata), 32'(cur_wr.data));
                end
                if (dmem_rd) begin
                    if (!prev_rd) begin
                        checkOutput("rd_queue_nonempty", 32'(exp_rd.size() > 0), 1);
                        if (exp_rd.size() > 0) cur_rd = exp_rd.pop_front();
                    end
                    checkOutput("rd_addr", 32'(dmem_addr), 32'(cur_rd));
                end
                checkOutput("rd_wr_exclusive", 32'(dmem_rd & dmem_wr), 0);
                checkOutput("imem_req_only_in_fetch", 32'(imem_req & (dmem_rd | dmem_wr)), 0);
            end
            prev_req = imem_req;
            prev_wr  = dmem_wr;
            prev_rd  = dmem_rd;
        end
    end

    task automatic wait_issued(input int n, input int limit);
        for (int c = 0; c < limit && issued < n && !m_halted; c++) @(negedge clk);
        checkOutput("progress", 32'(issued >= n || m_halted), 1);
    endtask

    // Main sequence: reset, directed program, random program, abort, halt.
    initial begin
        logic [15:0] v;
        reset = 1'b1;
        m_pc = '0;
        m_a  = '0;
        m_d  = '0;
        m_halted = 0;
        for (int i = 0; i < 32768; i++) begin
            v = 16'($urandom);
            ref_mem[i] = v;
            dut_mem[i] = v;
        end
        ref_mem[100] = 16'd3;
        dut_mem[100] = 16'd3;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_pc", 32'(pc), 0);
        checkOutput("reset_a", 32'(a_reg), 0);
        checkOutput("reset_d", 32'(d_reg), 0);
        checkOutput("reset_alu_control", 32'(alu_control), 0);
        checkOutput("reset_imem_req", 32'(imem_req), 0);
        checkOutput("reset_dmem_rd", 32'(dmem_rd), 0);
        checkOutput("reset_dmem_wr", 32'(dmem_wr), 0);

        applyStimulus(16'h0005);
        applyStimulus(16'h0007);
        applyStimulus(16'hEC10);
        applyStimulus(16'h0064);
        applyStimulus(16'hE308);
        applyStimulus(16'hF090);
        applyStimulus(16'h0014);
        applyStimulus(16'hE301);
        applyStimulus(16'hEA90);
        applyStimulus(16'h0014);
        applyStimulus(16'hE301);
        applyStimulus(16'hEE90);
        applyStimulus(16'h0014);
        applyStimulus(16'hE301);
        applyStimulus(16'h7FFF);
        applyStimulus(16'hEA87);
        applyStimulus(16'hEA90);
        budget += RANDOM_INSTR;

        exp_state.push_back('{15'h0, 16'h0, 16'h0, -1});
        checking = 1;
        @(posedge clk);
        #1 reset = 1'b0;

        wait_issued(ZERO_WAIT_INSTR, 5000);
        max_wait = 3;
        for (int c = 0; c < 60000 && budget > 0; c++) @(negedge clk);
        checkOutput("budget_drained", 32'(budget), 0);
        repeat (40) @(negedge clk);
        checkOutput("state_queue_drained", 32'(exp_state.size()), 0);
        checkOutput("wr_queue_drained", 32'(exp_wr.size()), 0);
        checkOutput("rd_queue_drained", 32'(exp_rd.size()), 0);

        checking = 0;
        hold_ack = 1;
        applyStimulus(16'hE308);
        for (int c = 0; c < 100 && !dmem_wr; c++) @(negedge clk);
        checkOutput("abort_write_started", 32'(dmem_wr), 1);
        repeat (2) @(negedge clk);
        checkOutput("abort_write_held", 32'(dmem_wr), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_wr_low", 32'(dmem_wr), 0);
        checkOutput("abort_req_low", 32'(imem_req), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        hold_ack = 0;
        @(negedge clk);
        checkOutput("abort_pc", 32'(pc), 0);
        checkOutput("abort_a", 32'(a_reg), 0);
        checkOutput("abort_d", 32'(d_reg), 0);
        checkOutput("abort_wr_after", 32'(dmem_wr), 0);
        checkOutput("abort_req_after", 32'(imem_req), 1);
        checkOutput("abort_alu_control", 32'(alu_control), 0);
        exp_state.delete();
        exp_wr.delete();
        exp_rd.delete();
        dir_words.delete();
        m_pc = '0;
        m_a  = '0;
        m_d  = '0;
        m_halted = 0;

        applyStimulus(16'h0000);
        applyStimulus(16'h0000);
        applyStimulus(16'h0000);
        applyStimulus(16'h0004);
        applyStimulus(16'hEA87);
`ifdef HACK_HALT_DETECT_EN
        for (int c = 0; c < 200 && !halted; c++) @(negedge clk);
        checkOutput("halted", 32'(halted), 1);
        repeat (5) @(negedge clk);
        checkOutput("halt_req_low", 32'(imem_req), 0);
        checkOutput("halt_strobes_low", 32'(dmem_rd | dmem_wr), 0);
        checkOutput("halt_pc", 32'(pc), 4);
`else
        for (int c = 0; c < 200 && budget > 0; c++) @(negedge clk);
        repeat (20) @(negedge clk);
        checkOutput("selfloop_pc", 32'(pc), 4);
        checkOutput("selfloop_a", 32'(a_reg), 4);
        checkOutput("selfloop_fetching", 32'(imem_req), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog in case the controller stops making progress.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
